// File: rtl/stack_pop_sequencer_pkg.sv
// Shared definitions for the return-instruction pop sequencer: state encoding,
// mode constants and width helpers reused by the hazard unit.
package stack_pop_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEAD   = 3'd1,
        ST_POP_F  = 3'd2,
        ST_POP_P  = 3'd3,
        ST_COMMIT = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_t;

    localparam logic MODE_RET = 1'b0;
    localparam logic MODE_RTI = 1'b1;

    // Bits needed to index 0..n-1, never less than one.
    function automatic int unsigned width_for(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stack_pop_sequencer.sv
// Multi-cycle RTI/RET sequencer: drains the pipeline, pops flag then PC words,
// strobes the write-backs and pulses done. One FSM, one shared step counter.
module stack_pop_sequencer
    import stack_pop_sequencer_pkg::*;
#(
    parameter int unsigned LEAD_CYCLES = 2,
    parameter int unsigned N_FLAG_SEGS = 1,
    parameter int unsigned N_PC_SEGS   = 2,
    parameter int unsigned SEG_IDX_W   = width_for(N_FLAG_SEGS + N_PC_SEGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 imm,
    input  logic                 stall,
    output logic                 busy,
    output logic                 pop,
    output logic [SEG_IDX_W-1:0] pop_segment,
    output logic                 write_flags,
    output logic                 write_pc,
    output logic                 inc_pc,
    output logic                 done
);

    localparam int unsigned N_SEGS = N_FLAG_SEGS + N_PC_SEGS;
    localparam int unsigned CNT_W  = width_for(max_u(LEAD_CYCLES, N_SEGS) + 1);

    localparam logic [CNT_W-1:0] LEAD_LAST =
        CNT_W'((LEAD_CYCLES > 0) ? LEAD_CYCLES - 1 : LEAD_CYCLES);
    localparam logic [CNT_W-1:0] FLAG_LAST = CNT_W'(N_FLAG_SEGS - 1);
    localparam logic [CNT_W-1:0] PC_FIRST  = CNT_W'(N_FLAG_SEGS);
    localparam logic [CNT_W-1:0] PC_LAST   = CNT_W'(N_SEGS - 1);

    seq_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_mode, w_mode_nxt;
    logic             r_imm, w_imm_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= MODE_RET;
            r_imm   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_imm   <= w_imm_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_imm_nxt   = r_imm;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_mode_nxt = mode;
                    w_imm_nxt  = imm;
                    if (LEAD_CYCLES > 0) begin
                        w_state_nxt = ST_LEAD;
                        w_cnt_nxt   = '0;
                    end else if (mode == MODE_RTI) begin
                        w_state_nxt = ST_POP_F;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_POP_P;
                        w_cnt_nxt   = PC_FIRST;
                    end
                end
            end
            ST_LEAD: begin
                w_imm_nxt = r_imm | imm;
                if (!stall) begin
                    if (r_cnt == LEAD_LAST) begin
                        // RET skips the flag words but keeps PC indices fixed.
                        w_state_nxt = (r_mode == MODE_RTI) ? ST_POP_F : ST_POP_P;
                        w_cnt_nxt   = (r_mode == MODE_RTI) ? '0 : PC_FIRST;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_POP_F: begin
                w_imm_nxt = r_imm | imm;
                if (!stall) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == FLAG_LAST) w_state_nxt = ST_POP_P;
                end
            end
            ST_POP_P: begin
                w_imm_nxt = r_imm | imm;
                if (!stall) begin
                    if (r_cnt == PC_LAST) begin
                        w_state_nxt = ST_COMMIT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                w_imm_nxt = r_imm | imm;
                if (!stall) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_imm_nxt   = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_imm_nxt   = 1'b0;
            end
        endcase
    end

    // Outputs decode from registered state; stall only masks the strobes.
    always_comb begin
        busy        = (r_state != ST_IDLE);
        pop         = 1'b0;
        pop_segment = '0;
        write_flags = 1'b0;
        write_pc    = 1'b0;
        inc_pc      = 1'b0;
        done        = 1'b0;

        unique case (r_state)
            ST_POP_F: begin
                pop         = !stall;
                pop_segment = SEG_IDX_W'(r_cnt);
            end
            ST_POP_P: begin
                pop         = !stall;
                pop_segment = SEG_IDX_W'(r_cnt);
                write_flags = !stall && (r_mode == MODE_RTI) && (r_cnt == PC_FIRST);
            end
            ST_COMMIT: begin
                write_pc = !stall;
                inc_pc   = !stall && r_imm;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule
